// File: rtl/ipsxe_floating_point_result_buf_v1_0.sv
// ipsxe_floating_point_result_buf_v1_0
// Result buffer behind the fixed-to-float converter. A small first-word-fall-through
// FIFO captures the converter's unstoppable tdata/tvalid stream and re-presents it as an
// AXI4-Stream master with tready backpressure. The converter is stalled through
// o_pipe_aclken early enough that a free slot always exists for a result still in flight.
// Optional status outputs are enabled with `define IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN.
module ipsxe_floating_point_result_buf_v1_0 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  i_aclk,
    input  logic                  i_areset_n,
    input  logic                  i_aclken,
    output logic                  o_pipe_aclken,
    input  logic [DATA_WIDTH-1:0] i_axi4s_result_tdata,
    input  logic                  i_axi4s_result_tvalid,
    output logic [DATA_WIDTH-1:0] o_axi4s_result_tdata,
    output logic                  o_axi4s_result_tvalid,
    input  logic                  i_axi4s_result_tready
`ifdef IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   o_fill_level,
    output logic [15:0]           o_stall_cnt,
    output logic                  o_dup_drop
`endif
);

    // Fill level needs one extra bit so that a completely full buffer is representable.
    localparam logic [ADDR_WIDTH:0] DepthC = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic [ADDR_WIDTH-1:0] wrPtr_q;
    logic [ADDR_WIDTH-1:0] wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q;
    logic [ADDR_WIDTH-1:0] rdPtr_d;
    logic                  adv_q;

    logic                  push;
    logic                  pop;
    logic                  outValid;
    logic                  pipeAclken;
    logic [ADDR_WIDTH:0]   levelWithPush;

    // Handshake decode, stall decision and next-state values for pointers and fill level.
    // A held (non-advanced) converter output is a duplicate, so only advanced words push.
    always_comb begin
        outValid      = (count_q != '0);
        push          = i_axi4s_result_tvalid & adv_q;
        pop           = outValid & i_axi4s_result_tready;
        levelWithPush = count_q + {{ADDR_WIDTH{1'b0}}, push};
        pipeAclken    = i_aclken & (levelWithPush < DepthC);

        wrPtr_d = push ? (wrPtr_q + ADDR_WIDTH'(1)) : wrPtr_q;
        rdPtr_d = pop  ? (rdPtr_q + ADDR_WIDTH'(1)) : rdPtr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, fill level and "upstream advanced on the last edge" state.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            count_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            adv_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            adv_q   <= pipeAclken;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge i_aclk) begin
        if (push) begin
            mem[wrPtr_q] <= i_axi4s_result_tdata;
        end
    end

    // First-word-fall-through presentation; data is forced to zero while empty.
    always_comb begin
        o_pipe_aclken         = pipeAclken;
        o_axi4s_result_tvalid = outValid;
        o_axi4s_result_tdata  = outValid ? mem[rdPtr_q] : '0;
    end

`ifdef IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN
    logic [15:0] stallCnt_q;
    logic        dupDrop_q;

    // Status: saturating count of back-pressure stalls and a pulse for each ignored held word.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            stallCnt_q <= '0;
            dupDrop_q  <= 1'b0;
        end else begin
            if (i_aclken && !pipeAclken && (stallCnt_q != 16'hFFFF)) begin
                stallCnt_q <= stallCnt_q + 16'd1;
            end
            dupDrop_q <= i_axi4s_result_tvalid & ~adv_q;
        end
    end

    // Status outputs are direct views of the status registers and the fill level.
    always_comb begin
        o_fill_level = count_q;
        o_stall_cnt  = stallCnt_q;
        o_dup_drop   = dupDrop_q;
    end
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_result_buf_v1_0.sv
// Testbench for ipsxe_floating_point_result_buf_v1_0.
// The converter is modelled as a one-stage pipeline fed from a queue of pending results;
// the buffer is modelled as a plain queue of words, and the whole accepted stream is
// compared against the whole delivered stream.
module tb_ipsxe_floating_point_result_buf_v1_0;

    localparam int DataWidth = 32;
    localparam int Depth     = 4;
    localparam int AddrWidth = 2;

    typedef struct packed {
        logic                 v;
        logic [DataWidth-1:0] d;
    } srcItem_t;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic                 aclken;
    logic                 pipeAclken;
    logic [DataWidth-1:0] upData;
    logic                 upValid;
    logic [DataWidth-1:0] outData;
    logic                 outValid;
    logic                 tready;
`ifdef IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN
    logic [AddrWidth:0]   fillLevel;
    logic [15:0]          stallCnt;
    logic                 dupDrop;
`endif

    ipsxe_floating_point_result_buf_v1_0 #(
        .DATA_WIDTH(DataWidth),
        .DEPTH     (Depth),
        .ADDR_WIDTH(AddrWidth)
    ) dut (
        .i_aclk               (clk),
        .i_areset_n           (rstN),
        .i_aclken             (aclken),
        .o_pipe_aclken        (pipeAclken),
        .i_axi4s_result_tdata (upData),
        .i_axi4s_result_tvalid(upValid),
        .o_axi4s_result_tdata (outData),
        .o_axi4s_result_tvalid(outValid),
        .i_axi4s_result_tready(tready)
`ifdef IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN
        ,
        .o_fill_level         (fillLevel),
        .o_stall_cnt          (stallCnt),
        .o_dup_drop           (dupDrop)
`endif
    );

    always #5 clk = ~clk;

    // Bench-side model state.
    srcItem_t             srcQ [$];
    logic [DataWidth-1:0] expQ [$];
    logic [DataWidth-1:0] sentQ [$];
    logic [DataWidth-1:0] recvQ [$];
    bit                   advM;
    bit                   pipeS;
    bit                   dupM;
    int                   stallM;
    int                   popCount;
    int                   vectors;
    int                   miscompares;

    logic [DataWidth-1:0] streamTbl [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic addSrc(input logic v, input logic [DataWidth-1:0] d);
        srcItem_t it;
        it.v = v;
        it.d = d;
        srcQ.push_back(it);
    endtask

    // Compares every DUT output with what the queue model says it must be right now.
    task automatic checkOutput();
        bit mValid;
        logic [DataWidth-1:0] mData;
        bit mPush;
        bit mPipe;
        mValid = (expQ.size() != 0);
        mData  = mValid ? expQ[0] : '0;
        mPush  = upValid && advM;
        mPipe  = aclken && ((expQ.size() + int'(mPush)) < Depth);
        checkVal("tvalid", 32'(outValid), 32'(mValid));
        checkVal("tdata", outData, mData);
        checkVal("pipe_aclken", 32'(pipeAclken), 32'(mPipe));
`ifdef IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN
        checkVal("fill_level", 32'(fillLevel), 32'(expQ.size()));
        checkVal("stall_cnt", 32'(stallCnt), 32'(stallM));
        checkVal("dup_drop", 32'(dupDrop), 32'(dupM));
`endif
    endtask

    // One clock cycle: advance the modelled converter, drive inputs, check, update model.
    task automatic applyStimulus(input bit rdy, input bit en);
        srcItem_t it;
        bit mPush;
        bit mPop;
        bit mPipe;
        @(negedge clk);
        if (pipeS) begin
            if (srcQ.size() > 0) begin
                it      = srcQ.pop_front();
                upValid = it.v;
                upData  = it.d;
            end else begin
                upValid = 1'b0;
                upData  = $urandom;
            end
            if (upValid) sentQ.push_back(upData);
        end
        tready = rdy;
        aclken = en;
        #1;
        checkOutput();
        mPush = upValid && advM;
        mPop  = (expQ.size() != 0) && rdy;
        mPipe = en && ((expQ.size() + int'(mPush)) < Depth);
        if (mPop) begin
            recvQ.push_back(outData);
            void'(expQ.pop_front());
            popCount++;
        end
        if (mPush) expQ.push_back(upData);
        if (en && !mPipe && stallM < 65535) stallM++;
        dupM  = upValid && !advM;
        advM  = mPipe;
        pipeS = mPipe;
    endtask

    // Delivered words must be the accepted words, in order, with nothing extra.
    task automatic checkSequence();
        checkVal("seq_len_ok", 32'(recvQ.size() <= sentQ.size()), 32'd1);
        for (int i = 0; i < recvQ.size(); i++) begin
            if (i < sentQ.size()) checkVal("seq_order", recvQ[i], sentQ[i]);
        end
    endtask

    task automatic clearModel();
        expQ.delete();
        sentQ.delete();
        recvQ.delete();
        srcQ.delete();
        advM     = 1'b0;
        pipeS    = 1'b0;
        dupM     = 1'b0;
        stallM   = 0;
        popCount = 0;
        upValid  = 1'b0;
        upData   = '0;
    endtask

    // Asynchronous reset in the middle of a cycle; release shortly after a rising edge.
    task automatic applyReset();
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkVal("rst_tvalid", 32'(outValid), 32'd0);
        checkVal("rst_tdata", outData, 32'd0);
        checkVal("rst_pipe", 32'(pipeAclken), 32'(aclken));
        checkSequence();
        clearModel();
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstN        = 1'b0;
        aclken      = 1'b1;
        tready      = 1'b0;
        clearModel();
        #3;
        checkVal("init_tvalid", 32'(outValid), 32'd0);
        checkVal("init_tdata", outData, 32'd0);
        checkVal("init_pipe", 32'(pipeAclken), 32'd1);
`ifdef IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN
        checkVal("init_fill", 32'(fillLevel), 32'd0);
        checkVal("init_stall", 32'(stallCnt), 32'd0);
        checkVal("init_dup", 32'(dupDrop), 32'd0);
`endif
        @(posedge clk);
        #2 rstN = 1'b1;

        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) addSrc(1'b1, streamTbl[i]);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkVal("stream_pipe", 32'(pipeAclken), 32'd1);
        end
        checkVal("stream_count", 32'(recvQ.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < recvQ.size()) checkVal("stream_word", recvQ[i], streamTbl[i]);
        end

        $display("[TB] full stall");
        for (int i = 0; i < 8; i++) addSrc(1'b1, 32'h40400000);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
        checkVal("full_pipe", 32'(pipeAclken), 32'd0);
        checkVal("full_tvalid", 32'(outValid), 32'd1);
        checkVal("full_level", 32'(expQ.size()), 32'd4);
`ifdef IPSXE_FLOATING_POINT_RESULT_BUF_STATUS_EN
        checkVal("full_fill", 32'(fillLevel), 32'd4);
`endif
        srcQ.delete();
        popCount = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1);
        checkVal("full_drain_pops", 32'(popCount), 32'd4);
        checkVal("full_drain_pipe", 32'(pipeAclken), 32'd1);

        $display("[TB] alternating ready across pointer wrap");
        for (int i = 0; i < 14; i++) addSrc(1'b1, 32'h00001000 + 32'(i));
        for (int i = 0; i < 40; i++) applyStimulus(1'(i % 2), 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);

        $display("[TB] global stall");
        addSrc(1'b1, 32'h3F000000);
        addSrc(1'b1, 32'h3E800000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
        checkVal("gstall_level", 32'(expQ.size()), 32'd2);
        popCount = 0;
        applyStimulus(1'b1, 1'b0);
        checkVal("gstall_pipe", 32'(pipeAclken), 32'd0);
        for (int i = 0; i < 3; i++) addSrc(1'b1, 32'hBF800000 - 32'(i));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkVal("gstall_pipe", 32'(pipeAclken), 32'd0);
        end
        checkVal("gstall_pops", 32'(popCount), 32'd2);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (srcQ.size() < 4) addSrc(1'($urandom_range(0, 9) < 7), $urandom);
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) addSrc(1'b1, 32'h42000000 + 32'(i));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);
        checkVal("prerst_level", 32'(expQ.size()), 32'd3);
        applyReset();
        addSrc(1'b1, 32'hC0000000);
        applyStimulus(1'b1, 1'b1);
        checkVal("postrst_c1_tvalid", 32'(outValid), 32'd0);
        applyStimulus(1'b1, 1'b1);
        checkVal("postrst_c2_tvalid", 32'(outValid), 32'd0);
        applyStimulus(1'b1, 1'b1);
        checkVal("postrst_c3_tvalid", 32'(outValid), 32'd1);
        checkVal("postrst_c3_tdata", outData, 32'hC0000000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);

        checkSequence();
        checkVal("final_empty", 32'(outValid), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
